// File: rtl/mips_decode_alu_pkg.sv
// Shared definitions for the MIPS decode/execute slice: opcodes, funct codes,
// ALUOp encodings, ALU select codes and control-word bit positions.
package mips_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALUOp field carried from ID to EX
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // ALU operation select; all eight codes are assigned so no code is undefined
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // Control-word bit positions
  localparam int CTL_REG_DST   = 8;
  localparam int CTL_ALU_SRC   = 7;
  localparam int CTL_MEM_TO_REG = 6;
  localparam int CTL_REG_WRITE = 5;
  localparam int CTL_MEM_READ  = 4;
  localparam int CTL_MEM_WRITE = 3;
  localparam int CTL_BRANCH    = 2;
  localparam int CTL_ALU_OP_HI = 1;
  localparam int CTL_ALU_OP_LO = 0;

  // Assemble a control word from its named fields
  function automatic logic [8:0] ctl_word(
    input logic       reg_dst,
    input logic       alu_src,
    input logic       mem_to_reg,
    input logic       reg_write,
    input logic       mem_read,
    input logic       mem_write,
    input logic       branch,
    input logic [1:0] alu_op
  );
    logic [8:0] w;
    w                              = 9'h000;
    w[CTL_REG_DST]                 = reg_dst;
    w[CTL_ALU_SRC]                 = alu_src;
    w[CTL_MEM_TO_REG]              = mem_to_reg;
    w[CTL_REG_WRITE]               = reg_write;
    w[CTL_MEM_READ]                = mem_read;
    w[CTL_MEM_WRITE]               = mem_write;
    w[CTL_BRANCH]                  = branch;
    w[CTL_ALU_OP_HI:CTL_ALU_OP_LO] = alu_op;
    return w;
  endfunction

endpackage

// File: rtl/mips_alu_core.sv
// Pure combinational ALU with zero flag. ADD/SUB wrap; SLT is signed,
// SLTU unsigned, both producing a zero-extended 0/1.
module mips_alu_core
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic [WIDTH-1:0] result_s;

  // Operation mux; every select code maps to a defined result
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (select)
      ALU_AND:  result_s = a & b;
      ALU_OR:   result_s = a | b;
      ALU_ADD:  result_s = a + b;
      ALU_XOR:  result_s = a ^ b;
      ALU_NOR:  result_s = ~(a | b);
      ALU_SLTU: result_s = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SUB:  result_s = a - b;
      ALU_SLT:  result_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  result_s = a + b;
    endcase
  end

  assign result = result_s;
  assign zero   = (result_s == {WIDTH{1'b0}});

endmodule

// File: rtl/mips_decode_alu.sv
// ID-stage main control decode, EX-stage ALU control and ALU, with the ALU
// result and zero flag also captured for the EX/MEM pipeline register.
module mips_decode_alu
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [5:0]       id_opcode,
  input  logic [1:0]       ex_alu_op,
  input  logic [5:0]       ex_funct,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [8:0]       id_control,
  output logic             id_half,
  output logic             id_half_unsigned,
  output logic [2:0]       alu_select,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_zero,
  output logic [WIDTH-1:0] alu_out_q,
  output logic             alu_zero_q
);

  logic [8:0]       control_s;
  logic             half_s;
  logic             half_unsigned_s;
  logic [2:0]       select_s;
  logic [WIDTH-1:0] alu_out_s;
  logic             alu_zero_s;
  logic [WIDTH-1:0] alu_out_r;
  logic             alu_zero_r;

  // Main control decode; unknown opcodes become a NOP with no writes
  always_comb begin
    control_s       = 9'h000;
    half_s          = 1'b0;
    half_unsigned_s = 1'b0;
    case (id_opcode)
      OP_RTYPE: control_s = ctl_word(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT);
      OP_ADDI:  control_s = ctl_word(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_ADD);
      OP_ANDI:  control_s = ctl_word(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_AND);
      OP_LW:    control_s = ctl_word(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD);
      OP_LH: begin
        control_s = ctl_word(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD);
        half_s    = 1'b1;
      end
      OP_LHU: begin
        control_s       = ctl_word(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD);
        half_s          = 1'b1;
        half_unsigned_s = 1'b1;
      end
      OP_SW:    control_s = ctl_word(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD);
      OP_BEQ:   control_s = ctl_word(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_SUB);
      default:  control_s = 9'h000;
    endcase
  end

  // ALU control; R-type funct codes outside the supported set fall back to ADD
  always_comb begin
    select_s = ALU_ADD;
    case (ex_alu_op)
      ALUOP_ADD: select_s = ALU_ADD;
      ALUOP_SUB: select_s = ALU_SUB;
      ALUOP_AND: select_s = ALU_AND;
      ALUOP_FUNCT: begin
        case (ex_funct)
          FN_ADD, FN_ADDU: select_s = ALU_ADD;
          FN_SUB, FN_SUBU: select_s = ALU_SUB;
          FN_AND:          select_s = ALU_AND;
          FN_OR:           select_s = ALU_OR;
          FN_XOR:          select_s = ALU_XOR;
          FN_NOR:          select_s = ALU_NOR;
          FN_SLT:          select_s = ALU_SLT;
          FN_SLTU:         select_s = ALU_SLTU;
          default:         select_s = ALU_ADD;
        endcase
      end
      default: select_s = ALU_ADD;
    endcase
  end

  mips_alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a      (alu_a),
    .b      (alu_b),
    .select (select_s),
    .result (alu_out_s),
    .zero   (alu_zero_s)
  );

  // EX/MEM capture of the ALU result; holds while the pipeline is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_r  <= {WIDTH{1'b0}};
      alu_zero_r <= 1'b0;
    end else if (en) begin
      alu_out_r  <= alu_out_s;
      alu_zero_r <= alu_zero_s;
    end else begin
      alu_out_r  <= alu_out_r;
      alu_zero_r <= alu_zero_r;
    end
  end

  assign id_control       = control_s;
  assign id_half          = half_s;
  assign id_half_unsigned = half_unsigned_s;
  assign alu_select       = select_s;
  assign alu_out          = alu_out_s;
  assign alu_zero         = alu_zero_s;
  assign alu_out_q        = alu_out_r;
  assign alu_zero_q       = alu_zero_r;

endmodule

// File: tb/tb_mips_decode_alu.sv
// Directed bench for mips_decode_alu: decode sweep, ALU control/ALU checks,
// and a scoreboard of expected registered results.
module tb_mips_decode_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [5:0]   id_opcode;
  logic [1:0]   ex_alu_op;
  logic [5:0]   ex_funct;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [8:0]   id_control;
  logic         id_half;
  logic         id_half_unsigned;
  logic [2:0]   alu_select;
  logic [W-1:0] alu_out;
  logic         alu_zero;
  logic [W-1:0] alu_out_q;
  logic         alu_zero_q;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard entries are {zero, out}
  logic [W:0]   sb_q[$];
  logic [W-1:0] pend_out;
  logic         pend_zero;
  logic [W-1:0] last_out;
  logic         last_zero;

  mips_decode_alu #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en               (en),
    .id_opcode        (id_opcode),
    .ex_alu_op        (ex_alu_op),
    .ex_funct         (ex_funct),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .id_control       (id_control),
    .id_half          (id_half),
    .id_half_unsigned (id_half_unsigned),
    .alu_select       (alu_select),
    .alu_out          (alu_out),
    .alu_zero         (alu_zero),
    .alu_out_q        (alu_out_q),
    .alu_zero_q       (alu_zero_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_alu(input logic [1:0] op, input logic [5:0] fn,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    ex_alu_op = op;
    ex_funct  = fn;
    alu_a     = a;
    alu_b     = b;
    #1;
  endtask

  task automatic expect_comb(input string tag, input logic [2:0] sel,
                             input logic [W-1:0] out, input logic zero);
    check({tag, "_sel"},  {29'd0, alu_select}, {29'd0, sel});
    check({tag, "_out"},  alu_out, out);
    check({tag, "_zero"}, {31'd0, alu_zero}, {31'd0, zero});
    pend_out  = out;
    pend_zero = zero;
  endtask

  // One rising edge: enqueue the pending expectation if enabled, then compare
  task automatic clock(input string tag);
    logic       en_v;
    logic [W:0] e;
    en_v = en;
    if (en_v) sb_q.push_back({pend_zero, pend_out});
    @(posedge clk);
    #1;
    if (en_v) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
        e         = sb_q.pop_front();
        last_out  = e[W-1:0];
        last_zero = e[W];
      end
    end
    check({tag, "_q"},  alu_out_q, last_out);
    check({tag, "_zq"}, {31'd0, alu_zero_q}, {31'd0, last_zero});
  endtask

  logic [5:0] dec_op  [8] = '{6'h08, 6'h00, 6'h23, 6'h21, 6'h25, 6'h2B, 6'h04, 6'h3F};
  logic [8:0] dec_ctl [8] = '{9'h0A0, 9'h122, 9'h0F0, 9'h0F0, 9'h0F0, 9'h088, 9'h005, 9'h000};
  logic [1:0] dec_hf  [8] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};

  logic [5:0]   fs_fn  [10] = '{6'h2A, 6'h2B, 6'h20, 6'h25, 6'h27, 6'h26, 6'h00, 6'h24, 6'h22, 6'h23};
  logic [2:0]   fs_sel [10] = '{3'b111, 3'b101, 3'b010, 3'b001, 3'b100, 3'b011, 3'b010, 3'b000, 3'b110, 3'b110};
  logic [W-1:0] fs_out [10] = '{32'h1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 32'h0, 32'h1,
                                32'hFFFFFFFE, 32'hFFFFFFFE};

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    id_opcode = 6'h00;
    last_out  = 32'h0;
    last_zero = 1'b0;
    pend_out  = 32'h0;
    pend_zero = 1'b0;
    drive_alu(2'b00, 6'h00, 32'h0, 32'h0);

    // reset state
    check("rst_q",  alu_out_q, 32'h0);
    check("rst_zq", {31'd0, alu_zero_q}, 32'h0);
    #2;
    rst_n = 1'b1;

    // decode sweep
    for (int i = 0; i < 8; i++) begin
      id_opcode = dec_op[i];
      #1;
      check($sformatf("dec_%02h_ctl", dec_op[i]), {23'd0, id_control}, {23'd0, dec_ctl[i]});
      check($sformatf("dec_%02h_half", dec_op[i]), {30'd0, id_half, id_half_unsigned},
            {30'd0, dec_hf[i]});
    end
    id_opcode = 6'h0C;
    #1;
    check("dec_0c_ctl", {23'd0, id_control}, 32'h0A3);

    // addi $s0,$0,50
    en = 1'b1;
    drive_alu(2'b00, 6'h00, 32'h0, 32'd50);
    expect_comb("addi", 3'b010, 32'd50, 1'b0);
    clock("addi");

    // beq equal / not equal
    drive_alu(2'b01, 6'h00, 32'h1234, 32'h1234);
    expect_comb("beq_eq", 3'b110, 32'h0, 1'b1);
    clock("beq_eq");
    drive_alu(2'b01, 6'h00, 32'd5, 32'd7);
    expect_comb("beq_ne", 3'b110, 32'hFFFFFFFE, 1'b0);
    clock("beq_ne");

    // R-type funct sweep with a=-1, b=1
    for (int i = 0; i < 10; i++) begin
      drive_alu(2'b10, fs_fn[i], 32'hFFFFFFFF, 32'h1);
      expect_comb($sformatf("fn_%02h", fs_fn[i]), fs_sel[i], fs_out[i], (fs_out[i] == 32'h0));
      clock($sformatf("fn_%02h", fs_fn[i]));
    end

    // SLT/SLTU with sign disagreement the other way
    drive_alu(2'b10, 6'h2A, 32'h1, 32'h80000000);
    expect_comb("slt_pos_neg", 3'b111, 32'h0, 1'b1);
    drive_alu(2'b10, 6'h2B, 32'h1, 32'h80000000);
    expect_comb("sltu_small_big", 3'b101, 32'h1, 1'b0);

    // andi path
    drive_alu(2'b11, 6'h3F, 32'h0000F0F0, 32'h00000FF0);
    expect_comb("andi", 3'b000, 32'h000000F0, 1'b0);
    clock("andi");

    // hold: en low for three clocks while alu_a changes
    drive_alu(2'b01, 6'h00, 32'd5, 32'd7);
    expect_comb("pre_hold", 3'b110, 32'hFFFFFFFE, 1'b0);
    clock("pre_hold");
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_alu(2'b01, 6'h00, 32'd7 + i, 32'd7);
      expect_comb($sformatf("hold%0d", i), 3'b110, i, (i == 0));
      clock($sformatf("hold%0d", i));
    end
    en = 1'b1;
    drive_alu(2'b01, 6'h00, 32'd7, 32'd7);
    expect_comb("resume", 3'b110, 32'h0, 1'b1);
    clock("resume");

    // asynchronous reset mid-cycle after a nonzero result
    drive_alu(2'b00, 6'h00, 32'd40, 32'd2);
    expect_comb("pre_rst", 3'b010, 32'd42, 1'b0);
    clock("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    last_out  = 32'h0;
    last_zero = 1'b0;
    check("arst_q",  alu_out_q, 32'h0);
    check("arst_zq", {31'd0, alu_zero_q}, 32'h0);
    check("arst_comb", alu_out, 32'd42);
    #1;
    rst_n = 1'b1;
    clock("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
